onehot_event_sequencer: RTL
===========================

// Module: onehot_event_sequencer
// PURPOSE
// - Transmit side of the one-hot event stream consumed by the latch/accumulator blocks.
// - Emits exactly one one-hot event per accepted transfer and never repeats an event.
// - Issues an event only after at least one of its prerequisites has been issued.
// - Raises done when all N events are issued, mirroring the consumer's all-ones prop.
// - Raises a sticky deadlock flag when no remaining event can become eligible.
// PARAMETERS
// - N         default 8   number of events (one-hot width); legal range 2..512
// - DEP_MASK  default '0  N*N bits; DEP_MASK[i*N +: N] = prerequisite set of event i
//                         (all-zero slice = no prerequisite; bit i of own slice ignored)
// PORTS
// - clk       in   1   single clock, rising edge
// - rst_n     in   1   asynchronous, active-low reset
// - start     in   1   pulse: begin a new sequence (honoured in IDLE or DONE only)
// - ev        out  N   one-hot event; all-zero when ev_valid=0
// - ev_valid  out  1   ev holds a legal event
// - ev_ready  in   1   consumer accepts; transfer = ev_valid & ev_ready
// - issued    out  N   set of events transferred so far this sequence
// - busy      out  1   state == RUN
// - done      out  1   issued == all-ones (level, held until next start)
// - deadlock  out  1   sticky: RUN, issued != all-ones, and no eligible event
// BEHAVIOUR
// - Reset values: state=IDLE, issued=0, ptr=0, ev=0, ev_valid=0, done=0, deadlock=0.
// - Eligibility, combinational from registered issued:
//   elig[i] = !issued[i] & (DEP_MASK_i==0 | |(DEP_MASK_i & issued)).
// - States:
//   - IDLE: outputs quiet. start -> RUN; clear issued, ptr, deadlock.
//   - RUN: on a transfer, issued |= ev and ptr = (idx(ev)+1) mod N.
//     - Leave RUN -> DONE on the cycle issued becomes all-ones.
//     - Leave RUN -> STALL when elig==0 with no pending event.
//   - DONE: done=1, ev_valid=0. start -> RUN with a fresh sequence.
//   - STALL: deadlock=1, ev_valid=0.
//     - start -> RUN with deadlock cleared. Otherwise STALL is held until reset.
// - ev/ev_valid are registered (1-cycle latency from eligibility to presentation).
// - Presentation: ev = round-robin pick of elig starting at ptr, wrapping N-1 -> 0.
// - Handshake rules:
//   - While ev_valid & !ev_ready, ev is held bit-stable even if eligibility changes.
//   - No ev_valid deassert without a transfer, except on reset.
//   - Back-to-back transfers: after an accept, the next event is presented the following cycle.
//   - Throughput is 1 event per 2 cycles; issued is updated before the next pick.
// - start during RUN is ignored. start concurrent with reset: reset wins.
// - Reset mid-sequence (rst_n low at any time): asynchronous return to reset values.
//   - ev_valid drops immediately, without waiting for clk.
// - Invariants:
//   - ev is one-hot or zero ($onehot0).
//   - ev & issued == 0.
//   - issued is monotonic within a sequence.
// STRUCTURE
// - Package onehot_seq_pkg:
//   - seq_state_e {IDLE, RUN, DONE, STALL}
//   - function onehot_to_idx(N-bit) -> clog2(N)
//   - function dep_slice(DEP_MASK, i)
// - Sub-module rr_onehot_arbiter #(N): req[N], ptr[clog2 N] -> gnt[N] one-hot, any.
//   - Implemented as a double-width masked priority pick.
// - Top: FSM, issued register, ptr register, output holding register, eligibility logic.
// TESTING (N=4 unless noted)
// - No deps, ev_ready=1, start
//   -> ev=0001,0010,0100,1000 on consecutive transfers; done=1; deadlock=0.
// - DEP: ev2 needs {ev0}, ev0 needs {ev3}
//   -> order 0010(ev1), 1000(ev3), 0001(ev0), 0100(ev2); done=1.
// - Backpressure: ev_ready=0 for 5 cycles while ev=0010
//   -> ev stable, issued unchanged; transfer on the first ready cycle.
// - Cycle: ev0 needs {ev1}, ev1 needs {ev0}
//   -> ev2, ev3 issued; then STALL, deadlock=1, issued=1100, done=0.
// - Reset pulse mid-RUN after 2 transfers
//   -> all outputs 0 asynchronously; new start restarts with issued=0.
// - Formal, N=406 with the codebase's dependency set
//   -> properties hold: $onehot0(ev), ev&issued==0, done => issued=='1.

Source files
------------

// File: rtl/onehot_seq_pkg.sv
// Shared types and helpers for the one-hot event sequencer.
// Helpers are sized for the widest legal event count and truncated by callers.
package onehot_seq_pkg;

    localparam int MAX_N     = 512;
    localparam int MAX_IDX_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        STALL
    } seq_state_e;

    // Encoder for a one-hot (or zero) vector: OR of the indices of the set bits.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    // Prerequisite set of event i in an n-event mask; an event never depends on itself.
    function automatic logic [MAX_N-1:0] dep_slice(input logic [MAX_N*MAX_N-1:0] mask,
                                                   input int n, input int i);
        logic [MAX_N-1:0] s;
        s = '0;
        for (int b = 0; b < n; b++) begin
            s[b] = mask[i*n + b];
        end
        s[i] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter.sv
// Round-robin one-hot pick of req starting at ptr, wrapping N-1 -> 0.
// Double-width trick: lowest set bit of {req, req masked to >= ptr}, folded back.
module rr_onehot_arbiter #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_gnt;

    assign hi_mask = {N{1'b1}} << ptr;
    assign dbl     = {req, req & hi_mask};
    // Lower half wins when anything at or above ptr is requesting.
    assign dbl_gnt = dbl & (~dbl + (2*N)'(1));
    assign gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    assign any     = |req;

endmodule

// File: rtl/onehot_event_sequencer.sv
// Issues each of N one-hot events exactly once, in dependency-respecting
// round-robin order, over a valid/ready stream; flags completion or deadlock.
module onehot_event_sequencer
    import onehot_seq_pkg::*;
#(
    parameter int             N        = 8,
    parameter logic [N*N-1:0] DEP_MASK = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] ev,
    output logic         ev_valid,
    input  logic         ev_ready,
    output logic [N-1:0] issued,
    output logic         busy,
    output logic         done,
    output logic         deadlock
);

    localparam int PW = $clog2(N);
    localparam logic [MAX_N*MAX_N-1:0] DEP_WIDE = (MAX_N*MAX_N)'(DEP_MASK);

    seq_state_e    state;
    logic [N-1:0]  issued_q;
    logic [N-1:0]  ev_q;
    logic          ev_valid_q;
    logic          done_q;
    logic          deadlock_q;
    logic [PW-1:0] ptr_q;

    logic [N-1:0]  elig;
    logic [N-1:0]  gnt;
    logic          gnt_any;
    logic [N-1:0]  issued_next;
    logic [PW-1:0] ev_idx;
    logic [PW-1:0] ptr_next;

    // An event is eligible once any one of its prerequisites has been issued.
    for (genvar i = 0; i < N; i++) begin : g_elig
        localparam logic [N-1:0] DEP_I = N'(dep_slice(DEP_WIDE, N, i));
        assign elig[i] = !issued_q[i] && ((DEP_I == '0) || (|(DEP_I & issued_q)));
    end

    rr_onehot_arbiter #(.N(N), .PW(PW)) u_arb (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .any (gnt_any)
    );

    always_comb begin
        issued_next = issued_q | ev_q;
        ev_idx      = PW'(onehot_to_idx(MAX_N'(ev_q)));
        ptr_next    = (ev_idx == PW'(N-1)) ? '0 : ev_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issued_q   <= '0;
            ptr_q      <= '0;
            ev_q       <= '0;
            ev_valid_q <= 1'b0;
            done_q     <= 1'b0;
            deadlock_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, STALL: begin
                    if (start) begin
                        state      <= RUN;
                        issued_q   <= '0;
                        ptr_q      <= '0;
                        ev_q       <= '0;
                        ev_valid_q <= 1'b0;
                        done_q     <= 1'b0;
                        deadlock_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (ev_valid_q && ev_ready) begin
                        issued_q   <= issued_next;
                        ptr_q      <= ptr_next;
                        ev_q       <= '0;
                        ev_valid_q <= 1'b0;
                        if (&issued_next) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else if (!ev_valid_q) begin
                        // Picks only from the settled issued set; a held event is never re-picked.
                        if (gnt_any) begin
                            ev_q       <= gnt;
                            ev_valid_q <= 1'b1;
                        end else begin
                            state      <= STALL;
                            deadlock_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ev       = ev_q;
    assign ev_valid = ev_valid_q;
    assign issued   = issued_q;
    assign busy     = (state == RUN);
    assign done     = done_q;
    assign deadlock = deadlock_q;

endmodule
